// File: rtl/pipelined_ram_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_ram_pkg
// Shared definitions for the pipelined RAM block.
//   READ_LATENCY_MIN / READ_LATENCY_MAX : legal range of the READ_LATENCY param
//   RESP_DATA_MAX_W                     : widest word the response record holds
//   resp_t                              : response record (read data + error)
// -----------------------------------------------------------------------------
package pipelined_ram_pkg;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;

   // Narrower words are zero-extended into the record.
   localparam int RESP_DATA_MAX_W = 512;

   typedef struct packed {
      logic [RESP_DATA_MAX_W-1:0] rdata;
      logic                       err;
   } resp_t;

endpackage

// File: rtl/pipelined_ram_resp_fifo.sv
// -----------------------------------------------------------------------------
// pipelined_ram_resp_fifo
// In-order response buffer between the read pipeline and the consumer.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (pointers/count only)
//   wr_en_i        : push wr_data_i (caller guarantees the FIFO is not full)
//   rd_en_i        : pop the head entry (caller guarantees not empty)
//   empty_o        : no entry buffered
//   rd_data_o      : head entry, valid while empty_o = 0
// -----------------------------------------------------------------------------
module pipelined_ram_resp_fifo
   import pipelined_ram_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic             empty_o,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en_i) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_en_i && !rd_en_i)      count_d = count_q + CNT_W'(1);
      else if (!wr_en_i && rd_en_i) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign empty_o   = (count_q == '0);
   assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/pipelined_ram.sv
// -----------------------------------------------------------------------------
// pipelined_ram
// Single-port byte-writable RAM with a valid/ready request channel and an
// in-order valid/ready response channel. Every accepted request (read or
// write) yields exactly one response READ_LATENCY cycles later, buffered in a
// FIFO sized so the request side can never overrun it.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid / req_ready         : request handshake
//   req_wstrb                     : byte enables, all zero = read
//   req_addr, req_wdata           : byte address, write data
//   resp_valid / resp_ready       : response handshake
//   resp_rdata, resp_err          : read data (0 for writes), out-of-range flag
// Build option:
//   PIPELINED_RAM_BOUNDS_CHECK_EN : word index >= WORDS suppresses the write and
//                                   answers rdata=0, err=1. Without it the index
//                                   wraps modulo WORDS (power of two) and err=0.
// -----------------------------------------------------------------------------
module pipelined_ram
   import pipelined_ram_pkg::*;
#(
   parameter int WORDS        = 256,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS_W = $clog2(STRB_W);
   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int DEPTH  = READ_LATENCY + 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int FW     = DATA_WIDTH + 1;

   if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("pipelined_ram: READ_LATENCY out of range");
   end
   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > RESP_DATA_MAX_W) begin : g_bad_width
      $error("pipelined_ram: DATA_WIDTH must be a multiple of 8 within the response record");
   end
`ifndef PIPELINED_RAM_BOUNDS_CHECK_EN
   if ((WORDS & (WORDS - 1)) != 0) begin : g_bad_words
      $error("pipelined_ram: WORDS must be a power of two when indices wrap");
   end
`endif

   logic [DATA_WIDTH-1:0] mem_q [WORDS];
   logic [CNT_W-1:0]      outstanding_q, outstanding_d;
   logic                  accept, resp_hs, is_write, oob;
   logic [ADDR_WIDTH-1:0] word_full;
   logic [IDX_W-1:0]      idx;
   logic                  vld_p0;
   logic [FW-1:0]         data_p0;
   logic                  fifo_wr, fifo_empty;
   logic [FW-1:0]         fifo_wdata, fifo_rdata;
   resp_t                 rsp;
   logic                  unused_ok;

   assign accept    = req_valid && req_ready;
   assign is_write  = |req_wstrb;
   assign word_full = req_addr >> OFFS_W;
   assign idx       = word_full[IDX_W-1:0];

`ifdef PIPELINED_RAM_BOUNDS_CHECK_EN
   assign oob = (word_full >= ADDR_WIDTH'(WORDS));
`else
   assign oob = 1'b0;
`endif

   // Array: byte-lane writes land at the accept edge; never reset.
   always_ff @(posedge clk) begin
      if (accept && !oob) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (req_wstrb[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   // Stage p0: accept cycle, array word selected combinationally so the first
   // register (pipeline or FIFO) captures it at the accept edge.
   always_comb begin
      vld_p0  = accept;
      data_p0 = '0;
      if (!is_write && !oob) data_p0[DATA_WIDTH-1:0] = mem_q[idx];
      data_p0[DATA_WIDTH] = oob;
   end

   // Stages p1..p(L-1): delay line; the FIFO write is the final stage.
   if (READ_LATENCY == 1) begin : g_lat1
      assign fifo_wr    = vld_p0;
      assign fifo_wdata = data_p0;
   end else begin : g_latn
      logic          vld_pn  [1:READ_LATENCY-1];
      logic [FW-1:0] data_pn [1:READ_LATENCY-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 1; s < READ_LATENCY; s++) vld_pn[s] <= 1'b0;
         end else begin
            vld_pn[1] <= vld_p0;
            for (int s = 2; s < READ_LATENCY; s++) vld_pn[s] <= vld_pn[s-1];
         end
      end

      always_ff @(posedge clk) begin
         data_pn[1] <= data_p0;
         for (int s = 2; s < READ_LATENCY; s++) data_pn[s] <= data_pn[s-1];
      end

      assign fifo_wr    = vld_pn[READ_LATENCY-1];
      assign fifo_wdata = data_pn[READ_LATENCY-1];
   end

   // Response buffer and output channel.
   pipelined_ram_resp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_resp_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (fifo_wr),
      .wr_data_i (fifo_wdata),
      .rd_en_i   (resp_hs),
      .empty_o   (fifo_empty),
      .rd_data_o (fifo_rdata)
   );

   // Outputs are gated by rst so they read idle during the reset cycle
   // itself, before the synchronous clear has taken effect.
   assign rsp        = '{rdata: RESP_DATA_MAX_W'(fifo_rdata[DATA_WIDTH-1:0]),
                         err:   fifo_rdata[DATA_WIDTH]};
   assign resp_valid = !rst && !fifo_empty;
   assign resp_hs    = resp_valid && resp_ready;
   assign resp_rdata = resp_valid ? rsp.rdata[DATA_WIDTH-1:0] : '0;
   assign resp_err   = resp_valid && rsp.err;

   // Outstanding count covers pipeline plus FIFO, so capping it at the FIFO
   // depth makes overflow impossible.
   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !resp_hs)      outstanding_d = outstanding_q + CNT_W'(1);
      else if (!accept && resp_hs) outstanding_d = outstanding_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) outstanding_q <= '0;
      else     outstanding_q <= outstanding_d;
   end

   assign req_ready = !rst && (outstanding_q < CNT_W'(DEPTH));

   // Upper record bits and high/low address bits are intentionally dropped.
   assign unused_ok = ^{rsp, word_full};

endmodule

// File: tb/tb_pipelined_ram.sv
// -----------------------------------------------------------------------------
// tb_pipelined_ram
// Two instances share clk/rst: index 0 has READ_LATENCY=2, index 1 has
// READ_LATENCY=3. Requests push expected responses into per-instance queues;
// a monitor forked from the main initial block pops and compares on every
// response handshake, and also checks output stability while stalled.
// -----------------------------------------------------------------------------
module tb_pipelined_ram;

`ifdef PIPELINED_RAM_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      bit          exact;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [3:0]  req_wstrb  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q0[$];
   exp_t exp_q1[$];

   logic        stall_m [2];
   logic [31:0] hold_d  [2];
   logic        hold_e  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipelined_ram #(
         .WORDS        (256),
         .DATA_WIDTH   (32),
         .ADDR_WIDTH   (32),
         .READ_LATENCY (g + 2)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_wstrb  (req_wstrb[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: actual no progress within cycle budget, required progress", name);
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // Called at the negedge of the accept cycle: response due L cycles later.
   task automatic expect_resp(input int i, input logic [31:0] d, input logic e, input bit exact);
      exp_t x;
      x.rdata = d;
      x.err   = e;
      x.due   = cyc + i + 2;
      x.exact = exact;
      if (i == 0) exp_q0.push_back(x);
      else        exp_q1.push_back(x);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               stall_m[i] = 1'b0;
            end else begin
               if (stall_m[i])
                  check($sformatf("hold%0d", i),
                        {31'd0, resp_valid[i], resp_err[i], resp_rdata[i]},
                        {31'd0, 1'b1, hold_e[i], hold_d[i]});
               if (resp_valid[i]) begin
                  if (qsize(i) == 0) begin
                     check($sformatf("stray_resp%0d", i), 64'(resp_valid[i]), 64'd0);
                  end else if (resp_ready[i]) begin
                     if (i == 0) e = exp_q0.pop_front();
                     else        e = exp_q1.pop_front();
                     check($sformatf("resp%0d", i), {31'd0, resp_err[i], resp_rdata[i]},
                           {31'd0, e.err, e.rdata});
                     if (e.exact) check($sformatf("resp_cycle%0d", i), 64'(cyc), 64'(e.due));
                     else         check($sformatf("resp_not_early%0d", i), 64'(cyc >= e.due), 64'd1);
                  end
               end
               stall_m[i] = resp_valid[i] && !resp_ready[i];
               hold_d[i]  = resp_rdata[i];
               hold_e[i]  = resp_err[i];
            end
         end
      end
   endtask

   // Drives one request from just after a posedge until it is accepted.
   task automatic issue(input int i, input logic [3:0] st, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input bit exact, output int waits);
      bit acc;
      req_valid[i] = 1'b1;
      req_wstrb[i] = st;
      req_addr[i]  = a;
      req_wdata[i] = d;
      waits = 0;
      acc   = 1'b0;
      while (!acc && waits <= 40) begin
         @(negedge clk);
         if (req_ready[i]) begin
            acc = 1'b1;
            expect_resp(i, er, ee, exact);
         end else begin
            waits++;
         end
      end
      if (!acc) fail_now("accept_timeout");
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      int n;
      n = 0;
      while (qsize(i) != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (qsize(i) != 0) fail_now("drain_timeout");
      @(posedge clk); #1;
   endtask

   initial begin
      int w;
      int acc;
      for (int i = 0; i < 2; i++) begin
         req_valid[i]  = 1'b0;
         req_wstrb[i]  = '0;
         req_addr[i]   = '0;
         req_wdata[i]  = '0;
         resp_ready[i] = 1'b1;
         stall_m[i]    = 1'b0;
         hold_d[i]     = '0;
         hold_e[i]     = 1'b0;
      end
      fork
         monitor();
      join_none

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("reset_outputs%0d", i),
               {29'd0, req_ready[i], resp_valid[i], resp_err[i], resp_rdata[i]}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("ready_after_reset%0d", i), 64'(req_ready[i]), 64'd1);
      @(posedge clk); #1;

      // Byte-lane merge, read-after-write, offset bits ignored (L=2)
      issue(0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, w);
      issue(0, 4'h2, 32'h10, 32'h0000AA00, 32'h0, 1'b0, 1'b1, w);
      issue(0, 4'h0, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, w);
      issue(0, 4'h0, 32'h13, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, w);
      drain(0);

      // Back-to-back reads with L=3, exact latency, ready never drops
      issue(1, 4'hF, 32'h0, 32'hA0A00000, 32'h0, 1'b0, 1'b1, w);
      issue(1, 4'hF, 32'h4, 32'hB1B11111, 32'h0, 1'b0, 1'b1, w);
      issue(1, 4'hF, 32'h8, 32'hC2C22222, 32'h0, 1'b0, 1'b1, w);
      drain(1);
      issue(1, 4'h0, 32'h0, 32'h0, 32'hA0A00000, 1'b0, 1'b1, w);
      check("b2b_ready0", 64'(w), 64'd0);
      issue(1, 4'h0, 32'h4, 32'h0, 32'hB1B11111, 1'b0, 1'b1, w);
      check("b2b_ready1", 64'(w), 64'd0);
      issue(1, 4'h0, 32'h8, 32'h0, 32'hC2C22222, 1'b0, 1'b1, w);
      check("b2b_ready2", 64'(w), 64'd0);
      drain(1);

      // Back-pressure with L=2: only READ_LATENCY+1 requests accepted
      for (int k = 0; k < 5; k++)
         issue(0, 4'hF, 32'(32'h20 + 4 * k), 32'(32'h50000000 + k), 32'h0, 1'b0, 1'b1, w);
      drain(0);
      resp_ready[0] = 1'b0;
      acc = 0;
      req_valid[0] = 1'b1;
      req_wstrb[0] = 4'h0;
      req_wdata[0] = 32'h0;
      req_addr[0]  = 32'h20;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            expect_resp(0, 32'(32'h50000000 + acc), 1'b0, 1'b0);
            acc++;
         end
         @(posedge clk); #1;
         req_addr[0] = 32'(32'h20 + 4 * acc);
      end
      @(negedge clk);
      check("accepted_count", 64'(acc), 64'd3);
      check("ready_when_full", 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      drain(0);
      @(negedge clk);
      check("ready_after_drain", 64'(req_ready[0]), 64'd1);
      @(posedge clk); #1;

      // Out-of-range word index (0x400 -> word 256)
      issue(1, 4'hF, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, w);
      issue(1, 4'hF, 32'h400, 32'h12345678, 32'h0, BC, 1'b1, w);
      issue(1, 4'h0, 32'h400, 32'h0, BC ? 32'h0 : 32'h12345678, BC, 1'b1, w);
      issue(1, 4'h0, 32'h0, 32'h0, BC ? 32'hCAFEF00D : 32'h12345678, 1'b0, 1'b1, w);
      drain(1);

      // Reset with responses buffered: discarded, array contents kept
      resp_ready[1] = 1'b0;
      issue(1, 4'h0, 32'h4, 32'h0, 32'hB1B11111, 1'b0, 1'b0, w);
      issue(1, 4'h0, 32'h8, 32'h0, 32'hC2C22222, 1'b0, 1'b0, w);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      resp_ready[1] = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      @(negedge clk);
      check("outputs_in_reset",
            {29'd0, req_ready[1], resp_valid[1], resp_err[1], resp_rdata[1]}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_midreset", 64'(req_ready[1]), 64'd1);
      check("valid_after_midreset", 64'(resp_valid[1]), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      issue(1, 4'h0, 32'h0, 32'h0, BC ? 32'hCAFEF00D : 32'h12345678, 1'b0, 1'b1, w);
      issue(1, 4'h0, 32'h4, 32'h0, 32'hB1B11111, 1'b0, 1'b1, w);
      drain(1);
      issue(0, 4'h0, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, 1'b1, w);
      drain(0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
